// File: rtl/arb_req_queue.sv
// Per-requester FIFO buffering in front of a round-robin arbiter, plus the registered output slot fed by its grant.
// Optional build macro ARB_REQ_QUEUE_STATS_EN adds per-requester saturating stall counters on port stall_cnt.
module arb_req_queue #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     in_data,
    output logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            gnt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic                          err
`ifdef ARB_REQ_QUEUE_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ID_W  = $clog2(NUM_REQ);

    logic [DATA_W-1:0] mem_q    [NUM_REQ][DEPTH];
    logic [DATA_W-1:0] mem_d    [NUM_REQ][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_REQ];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_REQ];
    logic [CNT_W-1:0]  cnt_q    [NUM_REQ];
    logic [CNT_W-1:0]  cnt_d    [NUM_REQ];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    logic              err_q,       err_d;

    logic               slot_free_c;
    logic [NUM_REQ-1:0] push_c;
    logic [NUM_REQ-1:0] pop_c;
    logic [NUM_REQ-1:0] cand_c;
    logic [ID_W-1:0]    sel_c;
    logic               sel_vld_c;
    logic               multi_gnt_c;

    // Handshake toward producers and request toward the arbiter; no gnt dependence here.
    always_comb begin
        slot_free_c = ~out_valid_q | out_ready;
        in_ready    = '0;
        req         = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            in_ready[i] = (cnt_q[i] != CNT_W'(DEPTH));
            req[i]      = (cnt_q[i] != '0) & slot_free_c;
        end
        push_c = in_valid & in_ready;
    end

    // Grant decode: ignore bits outside req, service the lowest remaining one.
    always_comb begin
        cand_c      = gnt & req;
        multi_gnt_c = |(gnt & (gnt - {{(NUM_REQ-1){1'b0}}, 1'b1}));
        sel_c       = '0;
        sel_vld_c   = 1'b0;
        pop_c       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!sel_vld_c && cand_c[i]) begin
                sel_c     = ID_W'(i);
                sel_vld_c = 1'b1;
                pop_c[i]  = 1'b1;
            end
        end
    end

    // FIFO storage, pointer and occupancy update.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (push_c[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i*DATA_W +: DATA_W];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop_c[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push_c[i], pop_c[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Output slot: load on pop, drain on out_ready, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        err_d       = err_q | multi_gnt_c;
        if (sel_vld_c) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[sel_c][rd_ptr_q[sel_c]];
            out_id_d    = sel_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign err       = err_q;

`ifdef ARB_REQ_QUEUE_STATS_EN
    logic [15:0] stall_q [NUM_REQ];
    logic [15:0] stall_d [NUM_REQ];

    // Saturating count of cycles a producer is held off by a full FIFO.
    always_comb begin
        stall_d   = stall_q;
        stall_cnt = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (in_valid[i] && !in_ready[i] && (stall_q[i] != 16'hFFFF)) begin
                stall_d[i] = stall_q[i] + 16'd1;
            end
            stall_cnt[i*16 +: 16] = stall_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed scoreboard bench for arb_req_queue with a behavioural round-robin arbiter (reset pointer 1).
module tb_arb_req_queue;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        err;
`ifdef ARB_REQ_QUEUE_STATS_EN
    logic [63:0] stall_cnt;
`endif

    arb_req_queue #(.NUM_REQ(4), .DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .err       (err)
`ifdef ARB_REQ_QUEUE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round-robin arbiter, overridable for protocol-error stimulus.
    logic       force_en;
    logic [3:0] force_gnt;
    logic [1:0] rr_ptr;
    logic [1:0] arb_idx;

    always_comb begin
        gnt     = '0;
        arb_idx = '0;
        if (force_en) begin
            gnt = force_gnt;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                arb_idx = rr_ptr + 2'(k);
                if (gnt == 4'b0000 && req[arb_idx]) gnt[arb_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd1;
        end else if (!force_en) begin
            for (int k = 0; k < 4; k++) begin
                if (gnt[k]) rr_ptr <= 2'(k);
            end
        end
    end

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors;
    int   checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; an output accepted at the coming edge is checked against the scoreboard.
    task automatic tick();
        exp_t e;
        #4;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_data), 32'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("sb_out_id", 32'(out_id), 32'(e.id));
                chk("sb_out_data", 32'(out_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_gnt = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        do_reset();

        // Reset / idle state.
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Single push on requester 2: req next cycle, output the cycle after.
        out_ready   = 1'b1;
        in_valid    = 4'b0100;
        in_data[23:16] = 8'hA1;
        sb.push_back('{id: 2'd2, data: 8'hA1});
        tick();
        in_valid = '0;
        chk("push_req", 32'(req), 32'h4);
        tick();
        chk("pop_out_valid", 32'(out_valid), 32'h1);
        chk("pop_out_data", 32'(out_data), 32'hA1);
        chk("pop_out_id", 32'(out_id), 32'h2);

        // One entry into the slot, then fill requester 0 behind a stalled output.
        in_valid  = 4'b0001;
        in_data[7:0] = 8'h0F;
        sb.push_back('{id: 2'd0, data: 8'h0F});
        tick();
        in_valid = '0;
        tick();
        out_ready = 1'b0;
        for (int v = 8'h10; v <= 8'h13; v++) begin
            in_valid     = 4'b0001;
            in_data[7:0] = 8'(v);
            sb.push_back('{id: 2'd0, data: 8'(v)});
            tick();
        end
        chk("full_in_ready", 32'(in_ready), 32'hE);
        in_data[7:0] = 8'h14;
        tick();
        chk("refused_in_ready", 32'(in_ready), 32'hE);
        chk("stall_req", 32'(req), 32'h0);
        chk("stall_out_valid", 32'(out_valid), 32'h1);
        chk("stall_out_data", 32'(out_data), 32'h0F);
        chk("stall_out_id", 32'(out_id), 32'h0);
        in_valid  = '0;
        out_ready = 1'b1;
        drain();

        // Second fill to exercise pointer wrap.
        out_ready = 1'b0;
        for (int v = 8'h20; v <= 8'h24; v++) begin
            in_valid     = 4'b0001;
            in_data[7:0] = 8'(v);
            sb.push_back('{id: 2'd0, data: 8'(v)});
            tick();
        end
        in_valid = '0;
        chk("wrap_full_in_ready", 32'(in_ready), 32'hE);
        chk("wrap_slot_data", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        drain();

        // Round-robin order from reset pointer 1 with all four queues occupied.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h33323130;
        sb.push_back('{id: 2'd2, data: 8'h32});
        sb.push_back('{id: 2'd3, data: 8'h33});
        sb.push_back('{id: 2'd0, data: 8'h30});
        sb.push_back('{id: 2'd1, data: 8'h31});
        tick();
        in_valid = '0;
        chk("rr_req", 32'(req), 32'hF);
        tick();
        chk("rr_first_id", 32'(out_id), 32'h2);
        drain();

        // Multi-bit grant: lowest requested bit served, error sticks.
        do_reset();
        out_ready = 1'b1;
        force_en  = 1'b1;
        force_gnt = 4'b0000;
        in_valid  = 4'b0110;
        in_data   = 32'h00424100;
        tick();
        in_valid = '0;
        chk("err_pre_req", 32'(req), 32'h6);
        chk("err_pre_err", 32'(err), 32'h0);
        force_gnt = 4'b0110;
        sb.push_back('{id: 2'd1, data: 8'h41});
        tick();
        force_gnt = 4'b1000;
        chk("err_set", 32'(err), 32'h1);
        chk("err_out_id", 32'(out_id), 32'h1);
        chk("err_out_data", 32'(out_data), 32'h41);
        chk("err_q2_kept", 32'(req), 32'h4);
        tick();
        chk("stray_gnt_no_pop", 32'(out_valid), 32'h0);
        chk("stray_gnt_req", 32'(req), 32'h4);
        chk("err_sticky", 32'(err), 32'h1);
        force_gnt = '0;
        force_en  = 1'b0;
        sb.push_back('{id: 2'd2, data: 8'h42});
        drain();
        chk("err_sticky_end", 32'(err), 32'h1);

        // Mid-operation reset discards buffered entries and the slot.
        out_ready = 1'b0;
        for (int v = 8'h50; v <= 8'h53; v++) begin
            in_valid     = 4'b0001;
            in_data[7:0] = 8'(v);
            tick();
        end
        in_valid = '0;
        chk("preflush_out_valid", 32'(out_valid), 32'h1);
        chk("preflush_req", 32'(req), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'hF);
        chk("flush_req", 32'(req), 32'h0);
        chk("flush_err", 32'(err), 32'h0);
        chk("flush_out_data", 32'(out_data), 32'h0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_stale", 32'(out_valid), 32'h0);

`ifdef ARB_REQ_QUEUE_STATS_EN
        // Stall counter saturation on requester 3.
        do_reset();
        chk("stats_reset", 32'(stall_cnt[63:48]), 32'h0);
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        in_data   = 32'h77000000;
        repeat (70000) tick();
        chk("stats_saturate", 32'(stall_cnt[63:48]), 32'hFFFF);
        chk("stats_other", 32'(stall_cnt[47:0]), 32'h0);
        in_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
